reg_file_ctx: RTL
=================

# reg_file_ctx

Parametrised successor to the Lab2 `reg_file`. It holds `2**ADDR_W` registers of `DATA_W` bits, with one write port and two combinational read ports. A dedicated pointer register drives `dr_code`, and a base register drives `data_outAddrBase`. It adds a shadow bank with a multi-cycle save/restore sequencer for context switches, and sits between the instruction decoder and the ALU/memory datapath.

## Interface
Parameters:
- `DATA_W`, 8: register width.
- `ADDR_W`, 4: address width; `NUM_REGS = 2**ADDR_W`.
- `DR_IDX`, 15: index of the data-register pointer register.
- `BASE_IDX`, 13: index of the address-base register.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `write_en`  in  1: write strobe.
- `waddr`  in  ADDR_W: write address.
- `data_in`  in  DATA_W: write data.
- `raddr_a`, `raddr_b`  in  ADDR_W: read addresses.
- `data_outA`, `data_outB`  out  DATA_W: combinational read data.
- `data_outAddrBase`  out  DATA_W: `registers[BASE_IDX]`.
- `dr_code`  out  ADDR_W: `registers[DR_IDX][ADDR_W-1:0]`.
- `copy_req`  in  1: start copying the active bank to the shadow bank.
- `restore_req`  in  1: start copying the shadow bank to the active bank.
- `busy`  out  1: sequencer is running.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Reads are combinational from the active bank; there is no read latency.
- Writes: on a rising edge with `write_en`=1, `registers[waddr] <= data_in`. Exception: writes are ignored in RESTORE.
- Reset clears all active and shadow registers to 0. Resulting output values: all data outputs 0, `dr_code`=0, `busy`=0, `done`=0, state IDLE, index counter 0.
- Sequencer FSM states: IDLE, SAVE, RESTORE.
  - IDLE with `copy_req`: go to SAVE, set idx=0, `busy`=1.
  - IDLE with `restore_req`: go to RESTORE, set idx=0, `busy`=1.
  - IDLE with both requests: `copy_req` wins.
  - SAVE, each edge: `shadow[idx] <= registers[idx]`.
  - RESTORE, each edge: `registers[idx] <= shadow[idx]`.
  - If idx = `NUM_REGS-1`: go to IDLE, `busy`<=0, `done`<=1. Otherwise idx<=idx+1.
- `done` clears on the next edge.
- Requests arriving while `busy`=1 are dropped, not queued.
- SAVE with a concurrent external write:
  - The write lands normally.
  - If `waddr`=idx on the same edge, shadow captures the pre-write value.
  - Writes to indices already saved are not reflected in the shadow bank.
- RESTORE: `write_en` is ignored for the whole operation, so restore has priority. Reads during RESTORE show the partially restored bank.
- Reset mid-operation aborts the sequence. Both banks clear, and no `done` pulse is issued.
- The counter is ADDR_W bits wide. Its terminal count is detected explicitly; it never wraps into a second pass.

## Timing
- `copy_req`/`restore_req` are sampled at edge N.
- `busy` is high from after edge N through edge N+NUM_REGS, i.e. exactly NUM_REGS cycles.
- Register idx transfers at edge N+1+idx.
- `done` is high for the single cycle after edge N+NUM_REGS, coincident with `busy` falling.
- A new request is accepted at the earliest on edge N+NUM_REGS+1.
- Written data is visible on read ports in the cycle after the write edge. The bypass option below changes this.
- `reset` has priority over all other inputs at every edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: when `write_en`=1 and the write is not blocked by RESTORE, read outputs forward `data_in` combinationally in the same cycle. This applies to a read port with `raddr`=`waddr`, to `data_outAddrBase` when `waddr`=BASE_IDX, and to `dr_code` when `waddr`=DR_IDX.
- Undefined: read outputs always show stored contents. A same-cycle read returns the old value.

## Test plan
Defaults: `DATA_W`=8, `ADDR_W`=4.
1. Assert `reset` for 2 cycles.
   -> `data_outA`, `data_outB` and `data_outAddrBase` all 0x00; `dr_code`=0, `busy`=0, `done`=0.
2. Write r[i]=0x4F-i for i=0..14 and r15=0x03. Then set `raddr_a`=0, `raddr_b`=14.
   -> A=0x4F, B=0x41, `data_outAddrBase`=0x42, `dr_code`=3.
3. Pulse `copy_req` one cycle. Then write r4=0xCE and pulse `restore_req`.
   -> `busy` high exactly 16 cycles for each operation, with one `done` pulse each.
   -> After restore, r4 reads 0x4B.
4. During RESTORE, drive `write_en`, `waddr`=5, `data_in`=0x00.
   -> After `done`, r5 reads 0x4A; the write was ignored.
5. Drive `write_en`, `waddr`=7, `data_in`=0xCA, `raddr_b`=7, and sample before the edge.
   -> With macro: B=0xCA. Without macro: B=0x48, then 0xCA after the edge.
6. Assert `reset` in the 5th SAVE cycle.
   -> `busy`=0 next cycle, no `done` pulse. A following restore yields all registers 0x00.

Source files
------------

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - register file with shadow bank and multi-cycle save/restore sequencer
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_ctx #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DR_IDX   = 15,
    parameter int BASE_IDX = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] data_outA,
    output logic [DATA_W-1:0] data_outB,
    output logic [DATA_W-1:0] data_outAddrBase,
    output logic [ADDR_W-1:0] dr_code,
    input  logic              copy_req,
    input  logic              restore_req,
    output logic              busy,
    output logic              done
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] DR_ADDR   = ADDR_W'(DR_IDX);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_IDX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] regs_q   [NUM_REGS];
    logic [DATA_W-1:0] regs_d   [NUM_REGS];
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];
    logic              wr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            regs_q   <= regs_d;
            shadow_q <= shadow_d;
        end
    end

    // The terminal index is compared explicitly so the counter never wraps into a second pass.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (copy_req) begin
                    state_d = ST_SAVE;
                    idx_d   = '0;
                end else if (restore_req) begin
                    state_d = ST_RESTORE;
                    idx_d   = '0;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = done_q;
    end

    assign wr_ok = write_en && (state_q != ST_RESTORE);

    // Shadow copies the pre-write value because it reads regs_q, not regs_d.
    always_comb begin
        regs_d   = regs_q;
        shadow_d = shadow_q;
        if (wr_ok) begin
            regs_d[waddr] = data_in;
        end
        if (state_q == ST_SAVE) begin
            shadow_d[idx_q] = regs_q[idx_q];
        end
        if (state_q == ST_RESTORE) begin
            regs_d[idx_q] = shadow_q[idx_q];
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data_outA        = (wr_ok && (raddr_a == waddr)) ? data_in : regs_q[raddr_a];
        data_outB        = (wr_ok && (raddr_b == waddr)) ? data_in : regs_q[raddr_b];
        data_outAddrBase = (wr_ok && (waddr == BASE_ADDR)) ? data_in : regs_q[BASE_ADDR];
        dr_code          = (wr_ok && (waddr == DR_ADDR)) ? data_in[ADDR_W-1:0]
                                                         : regs_q[DR_ADDR][ADDR_W-1:0];
    end
`else
    always_comb begin
        data_outA        = regs_q[raddr_a];
        data_outB        = regs_q[raddr_b];
        data_outAddrBase = regs_q[BASE_ADDR];
        dr_code          = regs_q[DR_ADDR][ADDR_W-1:0];
    end
`endif

endmodule
